// File: rtl/logic_reduce_seq.sv
// Sequential multi-operand bitwise reducer: folds a programmable number of W-bit
// operands from a valid/ready stream with AND/OR/XOR/XNOR and reports the result.
module logic_reduce_seq #(
   parameter int W = 8,
   parameter int N_MAX = 16,
   localparam int LEN_W = $clog2(N_MAX + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [LEN_W-1:0] len,
   input  logic [W-1:0]     din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             busy,
   output logic [W-1:0]     y,
   output logic             y_red,
   output logic             done_tick
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_MAX);

   state_t           state;
   logic [1:0]       op_q;
   logic [W-1:0]     acc;
   logic [LEN_W-1:0] cnt;

   // Starting value that leaves the first operand unchanged under each operator
   function automatic logic [W-1:0] identity(input logic [1:0] o);
      if (o == OP_AND || o == OP_XNOR)
         return '1;
      else
         return '0;
   endfunction

   function automatic logic [W-1:0] fold(input logic [1:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      case (o)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic logic reduce(input logic [1:0] o, input logic [W-1:0] a);
      case (o)
         OP_AND:  return &a;
         OP_OR:   return |a;
         OP_XOR:  return ^a;
         default: return ~^a;
      endcase
   endfunction

   // din_ready and busy are registered alongside the state so they track it exactly
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= OP_AND;
         acc       <= '0;
         cnt       <= '0;
         y         <= '0;
         y_red     <= 1'b0;
         done_tick <= 1'b0;
         din_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q <= op;
                  acc  <= identity(op);
                  cnt  <= (len > LEN_MAX) ? LEN_MAX : len;
                  busy <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                  end else begin
                     state     <= ACC;
                     din_ready <= 1'b1;
                  end
               end
            end
            ACC: begin
               if (din_valid && din_ready) begin
                  acc <= fold(op_q, acc, din);
                  cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     state     <= DONE;
                     din_ready <= 1'b0;
                  end
               end
            end
            DONE: begin
               y         <= acc;
               y_red     <= reduce(op_q, acc);
               done_tick <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               din_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_reduce_seq.sv
// Bench for logic_reduce_seq: directed and randomized reductions checked against
// a per-bit counting model of the four operators.
module tb_logic_reduce_seq;

   localparam int W = 8;
   localparam int N_MAX = 16;
   localparam int LEN_W = $clog2(N_MAX + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [1:0]       op;
   logic [LEN_W-1:0] len;
   logic [W-1:0]     din;
   logic             din_valid;
   logic             din_ready;
   logic             busy;
   logic [W-1:0]     y;
   logic             y_red;
   logic             done_tick;

   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_y;
   logic         exp_red;
   logic [W-1:0] beat_q [$];

   logic_reduce_seq #(.W(W), .N_MAX(N_MAX)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .len(len),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .busy(busy),
      .y(y),
      .y_red(y_red),
      .done_tick(done_tick)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Each result bit depends only on how many of the folded operands had that bit set
   function automatic logic [W-1:0] refFold(input logic [1:0] o, input int n);
      logic [W-1:0] r;
      for (int b = 0; b < W; b++) begin
         int ones = 0;
         for (int i = 0; i < n; i++)
            ones += int'(beat_q[i][b]);
         case (o)
            2'd0:    r[b] = (ones == n);
            2'd1:    r[b] = (ones > 0);
            2'd2:    r[b] = (ones % 2 == 1);
            default: r[b] = ((n - ones) % 2 == 0);
         endcase
      end
      return r;
   endfunction

   function automatic logic refRed(input logic [1:0] o, input logic [W-1:0] v);
      int c = $countones(v);
      case (o)
         2'd0:    return c == W;
         2'd1:    return c > 0;
         2'd2:    return c % 2 == 1;
         default: return c % 2 == 0;
      endcase
   endfunction

   task automatic applyStimulus(input logic [1:0] op_v, input int len_v,
                                input int min_gap, input int max_gap,
                                input bit poke_idle, input bit mid_start,
                                input bit extra_beat);
      int eff;
      int gaps;
      eff = (len_v > N_MAX) ? N_MAX : len_v;
      if (poke_idle) begin
         din_valid = 1'b1;
         din = W'($urandom);
         checkOutput("idle_ready", 32'(din_ready), 32'd0);
         tick();
         din_valid = 1'b0;
         checkOutput("idle_busy", 32'(busy), 32'd0);
      end
      start = 1'b1;
      op = op_v;
      len = LEN_W'(len_v);
      tick();
      start = 1'b0;
      op = 2'($urandom);
      len = LEN_W'($urandom);
      for (int i = 0; i < eff; i++) begin
         gaps = $urandom_range(max_gap, min_gap);
         repeat (gaps) begin
            din_valid = 1'b0;
            if (mid_start) start = 1'b1;
            checkOutput("gap_ready", 32'(din_ready), 32'd1);
            checkOutput("gap_busy", 32'(busy), 32'd1);
            checkOutput("gap_done", 32'(done_tick), 32'd0);
            checkOutput("gap_y_held", 32'(y), 32'(exp_y));
            tick();
            start = 1'b0;
         end
         din_valid = 1'b1;
         din = beat_q[i];
         checkOutput("beat_ready", 32'(din_ready), 32'd1);
         checkOutput("beat_busy", 32'(busy), 32'd1);
         tick();
      end
      din_valid = extra_beat;
      din = W'($urandom);
      checkOutput("final_ready", 32'(din_ready), 32'd0);
      checkOutput("final_busy", 32'(busy), 32'd1);
      checkOutput("final_no_done", 32'(done_tick), 32'd0);
      checkOutput("final_y_held", 32'(y), 32'(exp_y));
      tick();
      din_valid = 1'b0;
      exp_y = refFold(op_v, eff);
      exp_red = refRed(op_v, exp_y);
      checkOutput("done_tick", 32'(done_tick), 32'd1);
      checkOutput("result_y", 32'(y), 32'(exp_y));
      checkOutput("result_y_red", 32'(y_red), 32'(exp_red));
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_ready", 32'(din_ready), 32'd0);
      tick();
      checkOutput("single_done", 32'(done_tick), 32'd0);
      checkOutput("y_hold", 32'(y), 32'(exp_y));
      checkOutput("y_red_hold", 32'(y_red), 32'(exp_red));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op = 2'd0;
      len = '0;
      din = '0;
      din_valid = 1'b0;
      exp_y = '0;
      exp_red = 1'b0;
      tick();
      tick();
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_y_red", 32'(y_red), 32'd0);
      checkOutput("rst_done", 32'(done_tick), 32'd0);
      checkOutput("rst_ready", 32'(din_ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] AND of three back-to-back beats");
      beat_q = '{8'hF0, 8'hCC, 8'hAA};
      applyStimulus(2'd0, 3, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] XOR with idle gaps between beats");
      beat_q = '{8'h01, 8'h02, 8'h04, 8'h08};
      applyStimulus(2'd2, 4, 1, 3, 1'b0, 1'b0, 1'b0);

      $display("[TB] zero-length OR then AND");
      beat_q.delete();
      applyStimulus(2'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset in the middle of an OR reduction");
      start = 1'b1;
      op = 2'd1;
      len = LEN_W'(5);
      tick();
      start = 1'b0;
      din_valid = 1'b1;
      din = 8'h0F;
      tick();
      din = 8'h30;
      tick();
      din = 8'hC0;
      reset = 1'b1;
      tick();
      exp_y = '0;
      exp_red = 1'b0;
      checkOutput("mid_rst_y", 32'(y), 32'd0);
      checkOutput("mid_rst_y_red", 32'(y_red), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_ready", 32'(din_ready), 32'd0);
      checkOutput("mid_rst_done", 32'(done_tick), 32'd0);
      reset = 1'b0;
      din_valid = 1'b0;
      tick();
      checkOutput("post_rst_done", 32'(done_tick), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      beat_q = '{8'h11, 8'h22};
      applyStimulus(2'd1, 2, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] start during ACC and valid during IDLE are ignored");
      beat_q = '{8'h5A, 8'h3C, 8'hF1, 8'h87};
      applyStimulus(2'd2, 4, 1, 2, 1'b1, 1'b1, 1'b0);

      $display("[TB] XNOR with length above N_MAX saturates");
      beat_q.delete();
      for (int i = 0; i < N_MAX; i++) beat_q.push_back(8'h00);
      applyStimulus(2'd3, 20, 0, 0, 1'b0, 1'b0, 1'b1);

      $display("[TB] randomized reductions");
      for (int k = 0; k < 12; k++) begin
         beat_q.delete();
         for (int i = 0; i < N_MAX; i++) beat_q.push_back(W'($urandom));
         applyStimulus(2'($urandom), $urandom_range(20, 0), 0, 2,
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       1'($urandom_range(1, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_reduce_seq.md
Name: logic_reduce_seq

Overview:
Parametrised, sequential multi-operand bitwise reduction engine. After a start command it accepts a programmable number of W-bit operands over a valid/ready stream and folds them with a selectable operator (AND/OR/XOR/XNOR). It then presents the W-bit result and a 1-bit reduction of that result. It is the general-purpose successor to the fixed 3-input gate blocks in the lab designs, and sits between a switch/UART operand source and the LED/display output logic.

Parameters:
W, 8, operand and result width in bits (W >= 1)
N_MAX, 16, maximum operands per reduction (N_MAX >= 1); localparam LEN_W = $clog2(N_MAX+1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a reduction; sampled only in IDLE
op  input  2  operator: 00 AND, 01 OR, 10 XOR, 11 XNOR; latched on accepted start
len  input  LEN_W  operand count; latched on accepted start
din  input  W  operand data
din_valid  input  1  din is valid this cycle
din_ready  output  1  block accepts din this cycle
busy  output  1  high in any state other than IDLE
y  output  W  last completed result; held until the next completion
y_red  output  1  op applied across all bits of y (&y, |y, ^y, ~^y)
done_tick  output  1  one-cycle pulse: y/y_red updated this cycle

Behaviour:
- Clock is clk. Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, acc=0, cnt=0, y=0, y_red=0, done_tick=0, din_ready=0, busy=0.
- Reset takes priority over every other input, including mid-reduction. The partial accumulation is discarded and no done_tick is issued.
- FSM states: IDLE, ACC, DONE.
- IDLE: din_ready=0, busy=0. din_valid is ignored.
  - On start=1, latch op and len.
  - Load acc with the op identity: all-ones for AND/XNOR, all-zeros for OR/XOR.
  - Load cnt = min(len, N_MAX). Values above N_MAX saturate to N_MAX.
  - If the effective length is 0, go to DONE; otherwise go to ACC.
- ACC: din_ready=1, busy=1.
  - A beat is accepted when din_valid & din_ready: acc <= acc op din; cnt <= cnt-1.
  - Accepting the beat with cnt==1 moves to DONE.
  - Cycles with din_valid=0 hold state. There is no timeout.
- DONE: din_ready=0, busy=1. For one cycle: y <= acc, y_red <= reduction of acc, done_tick=1 (registered, aligned with the new y). Return to IDLE.
- Latency:
  - The last beat accepted at edge k gives y/done_tick valid in the cycle after edge k+1.
  - A zero-length start gives done_tick two cycles after start is sampled.
  - Minimum spacing between consecutive starts: len+2 cycles.
- start while busy is ignored, and is not queued. op/len changes while busy have no effect.
- y and y_red change only on done_tick or reset.
- The operator is applied bitwise. No carry, no width growth. acc is exactly W bits.

Test Plan:
1. W=8; op=AND, len=3; din 0xF0, 0xCC, 0xAA on consecutive cycles with valid high -> exactly 3 beats accepted; y=0x80, y_red=0; single done_tick two cycles after the third accept.
2. op=XOR, len=4; din 0x01, 0x02, 0x04, 0x08 with 1-3 idle cycles between valids -> y=0x0F, y_red=0; din_ready stays high through the gaps; busy high throughout.
3. len=0 with op=OR -> y=0x00, y_red=0. Then len=0 with op=AND -> y=0xFF, y_red=1. Each done_tick arrives 2 cycles after start, with no din_ready assertion.
4. start pulsed mid-ACC, and din_valid driven in IDLE -> both ignored; the result equals the uninterrupted reduction; no extra done_tick.
5. reset asserted after 2 of 5 beats (op=OR) -> next cycle IDLE with y=0, busy=0, din_ready=0, no done_tick. A following OR reduction of len=2 over 0x11, 0x22 gives y=0x33, y_red=1.
6. len=20 (>N_MAX=16), op=XNOR, sixteen beats of 0x00 -> done_tick after the 16th accept; a 17th valid beat is not accepted; y=0xFF, y_red=1.
